// File: rtl/dda_seq_pkg.sv
// Shared constants, FSM encoding and opcode argument table
// for the DDA UART command sequencer.
package dda_seq_pkg;

    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_RUN   = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] ACK_BYTE = 8'hA5;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    localparam int QDEPTH = 8;
    localparam int QW     = QDEPTH * 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARGS   = 3'd1,
        ST_RUN    = 3'd2,
        ST_RESP   = 3'd3,
        ST_WAITTX = 3'd4
    } state_t;

    function automatic logic [3:0] arg_count(
        input logic [7:0] op
    );
        unique case (1'b1)
            op == OP_LOAD: arg_count = 4'd10;
            op == OP_RUN:  arg_count = 4'd2;
            default:       arg_count = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/dda_seq_if.sv
// UART-side byte handshake between the host link
// and the DDA sequencer.
interface dda_seq_if;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_byte;

    modport master (
        output rx_valid, rx_byte, tx_busy,
        input  tx_start, tx_byte
    );

    modport slave (
        input  rx_valid, rx_byte, tx_busy,
        output tx_start, tx_byte
    );

endinterface

// File: rtl/dda_seq_txq.sv
// Response byte queue: loaded as a whole frame,
// drained one byte at a time, byte 0 first.
module dda_seq_txq
    import dda_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [QW-1:0] data,
    input  logic [3:0]    len,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          empty
);

    logic [QW-1:0] mem;
    logic [3:0]    rd;
    logic [3:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
            rd  <= '0;
            cnt <= '0;
        end else if (load) begin
            mem <= data;
            rd  <= '0;
            cnt <= len;
        end else if (pop && !empty) begin
            rd <= rd + 4'd1;
        end
    end

    assign head  = mem[{rd[2:0], 3'b000} +: 8];
    assign empty = (rd == cnt);

endmodule

// File: rtl/dda_sequencer.sv
// UART command sequencer for the posit DDA (LOAD/RUN/READ).
// Define DDA_SEQ_CHECKSUM_EN to append an XOR byte to each response.
module dda_sequencer
    import dda_seq_pkg::*;
#(
    parameter int N           = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    dda_seq_if.slave     bus,
    output logic         dda_en,
    output logic [N-1:0] ic1,
    output logic [N-1:0] ic2,
    output logic [N-1:0] vK_M,
    output logic [N-1:0] vD_M,
    output logic [N-1:0] dt,
    input  logic [N-1:0] v1,
    input  logic [N-1:0] v2,
    output logic         busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state;
    logic [7:0]    op_q;
    logic [3:0]    idx;
    logic [71:0]   sh;
    logic [15:0]   steps;
    logic [TW-1:0] timer;
    logic          seen_busy;

    logic [79:0]   frame;
    logic          last;
    logic [15:0]   v1w;
    logic [15:0]   v2w;
    logic          b_load;
    logic [QW-1:0] b_data;
    logic [3:0]    b_len;
    logic [QW-1:0] q_data;
    logic [3:0]    q_len;
    logic          q_pop;
    logic [7:0]    q_head;
    logic          q_empty;

    assign frame = {sh, bus.rx_byte};
    assign last  = (idx == arg_count(op_q) - 4'd1);
    assign v1w   = 16'(v1);
    assign v2w   = 16'(v2);
    assign busy  = (state != ST_IDLE);
    assign q_pop = (state == ST_RESP) && !bus.tx_busy;

    always_comb begin
        b_load = 1'b0;
        b_data = '0;
        b_len  = 4'd1;
        case (state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte == OP_READ) begin
                        b_load       = 1'b1;
                        b_data[31:0] = {v2w[7:0], v2w[15:8],
                                        v1w[7:0], v1w[15:8]};
                        b_len        = 4'd4;
                    end else if (arg_count(bus.rx_byte) == 4'd0) begin
                        b_load      = 1'b1;
                        b_data[7:0] = ERR_BYTE;
                    end
                end
            end
            ST_ARGS: begin
                if (bus.rx_valid && last &&
                    (op_q == OP_LOAD || frame[15:0] == 16'd0)) begin
                    b_load      = 1'b1;
                    b_data[7:0] = ACK_BYTE;
                end
            end
            ST_RUN: begin
                if (steps == 16'd1) begin
                    b_load      = 1'b1;
                    b_data[7:0] = ACK_BYTE;
                end
            end
            default: ;
        endcase
    end

`ifdef DDA_SEQ_CHECKSUM_EN
    logic [7:0] ck;

    // unused queue bytes are zero, so folding all of them is safe
    always_comb begin
        ck = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            ck = ck ^ b_data[i*8 +: 8];
        end
        q_data = b_data | (QW'(ck) << {b_len, 3'b000});
        q_len  = b_len + 4'd1;
    end
`else
    assign q_data = b_data;
    assign q_len  = b_len;
`endif

    dda_seq_txq u_txq (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (b_load),
        .data  (q_data),
        .len   (q_len),
        .pop   (q_pop),
        .head  (q_head),
        .empty (q_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            op_q         <= '0;
            idx          <= '0;
            sh           <= '0;
            steps        <= '0;
            timer        <= '0;
            seen_busy    <= 1'b0;
            dda_en       <= 1'b0;
            bus.tx_start <= 1'b0;
            bus.tx_byte  <= '0;
            ic1          <= '0;
            ic2          <= '0;
            vK_M         <= '0;
            vD_M         <= '0;
            dt           <= '0;
        end else begin
            bus.tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        op_q  <= bus.rx_byte;
                        idx   <= '0;
                        timer <= '0;
                        if (arg_count(bus.rx_byte) != 4'd0)
                            state <= ST_ARGS;
                        else
                            state <= ST_RESP;
                    end
                end
                ST_ARGS: begin
                    if (bus.rx_valid) begin
                        timer <= '0;
                        sh    <= frame[71:0];
                        idx   <= idx + 4'd1;
                        if (last) begin
                            if (op_q == OP_LOAD) begin
                                ic1   <= N'(frame[79:64]);
                                ic2   <= N'(frame[63:48]);
                                vK_M  <= N'(frame[47:32]);
                                vD_M  <= N'(frame[31:16]);
                                dt    <= N'(frame[15:0]);
                                state <= ST_RESP;
                            end else if (frame[15:0] == 16'd0) begin
                                state <= ST_RESP;
                            end else begin
                                steps  <= frame[15:0];
                                dda_en <= 1'b1;
                                state  <= ST_RUN;
                            end
                        end
                    end else if (timer == TW'(TIMEOUT_CYC)) begin
                        timer <= '0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RUN: begin
                    steps <= steps - 16'd1;
                    if (steps == 16'd1) begin
                        dda_en <= 1'b0;
                        state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_byte  <= q_head;
                        seen_busy    <= 1'b0;
                        state        <= ST_WAITTX;
                    end
                end
                ST_WAITTX: begin
                    if (bus.tx_busy)
                        seen_busy <= 1'b1;
                    else if (seen_busy)
                        state <= q_empty ? ST_IDLE : ST_RESP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dda_sequencer.sv
// Directed bench for dda_sequencer: vector table of command
// frames plus hand sequences for timeout, drop and reset.
module tb_dda_sequencer;

    localparam int TO = 40;
`ifdef DDA_SEQ_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dda_en;
    logic        busy;
    logic [15:0] ic1, ic2, vK_M, vD_M, dt;
    logic [15:0] v1, v2;

    always #5 clk = ~clk;

    dda_seq_if u_if();

    dda_sequencer #(.N(16), .TIMEOUT_CYC(TO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (u_if.slave),
        .dda_en (dda_en),
        .ic1    (ic1),
        .ic2    (ic2),
        .vK_M   (vK_M),
        .vD_M   (vD_M),
        .dt     (dt),
        .v1     (v1),
        .v2     (v2),
        .busy   (busy)
    );

    int         checks = 0;
    int         errors = 0;
    int         ntx = 0;
    int         en_cnt = 0;
    int         bcnt = 0;
    logic [7:0] rxq[$];

    // UART transmitter model: busy for 3 cycles per byte
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_if.tx_busy <= 1'b0;
            bcnt <= 0;
        end else begin
            if (dda_en) en_cnt <= en_cnt + 1;
            if (u_if.tx_start) begin
                rxq.push_back(u_if.tx_byte);
                ntx <= ntx + 1;
                u_if.tx_busy <= 1'b1;
                bcnt <= 3;
            end else if (bcnt == 1) begin
                u_if.tx_busy <= 1'b0;
                bcnt <= 0;
            end else if (bcnt > 1) begin
                bcnt <= bcnt - 1;
            end
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        u_if.rx_valid = 1'b1;
        u_if.rx_byte  = b;
        @(negedge clk);
        u_if.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle"}, busy, 0);
    endtask

    typedef struct {
        logic [87:0] tx;
        int          nb;
        logic [39:0] rs;
        int          nr;
        int          en;
    } vec_t;

    vec_t vt[5];

    initial begin
        int         q0, e0, s0, expn;
        logic [7:0] x, act;

        vt[0] = '{88'h01_0040_0020_4000_1000_0008, 11,
                  {8'hA5, 32'h0}, 1, 0};
        vt[1] = '{{24'h020005, 64'h0}, 3, {8'hA5, 32'h0}, 1, 5};
        vt[2] = '{{24'h020000, 64'h0}, 3, {8'hA5, 32'h0}, 1, 0};
        vt[3] = '{{8'h03, 80'h0}, 1, {32'h1234ABCD, 8'h0}, 4, 0};
        vt[4] = '{{8'h7F, 80'h0}, 1, {8'hEE, 32'h0}, 1, 0};

        u_if.rx_valid = 1'b0;
        u_if.rx_byte  = 8'h00;
        v1 = 16'h1234;
        v2 = 16'hABCD;
        #1;
        chk("rst_dda_en", dda_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_start", u_if.tx_start, 0);
        chk("rst_tx_byte", u_if.tx_byte, 0);
        chk("rst_ic1", ic1, 0);
        chk("rst_dt", dt, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            q0 = rxq.size();
            e0 = en_cnt;
            for (int k = 0; k < vt[i].nb; k++)
                send(vt[i].tx[87-8*k -: 8]);
            wait_idle($sformatf("v%0d", i));
            expn = vt[i].nr + CK;
            chk($sformatf("v%0d_len", i), rxq.size() - q0, expn);
            x = 8'h00;
            for (int k = 0; k < expn; k++) begin
                act = (q0 + k < rxq.size()) ? rxq[q0+k] : 8'hxx;
                if (k < vt[i].nr) begin
                    chk($sformatf("v%0d_b%0d", i, k), act,
                        vt[i].rs[39-8*k -: 8]);
                    x = x ^ vt[i].rs[39-8*k -: 8];
                end else begin
                    chk($sformatf("v%0d_ck", i), act, x);
                end
            end
            chk($sformatf("v%0d_en", i), en_cnt - e0, vt[i].en);
        end

        chk("ld_ic1", ic1, 16'h0040);
        chk("ld_ic2", ic2, 16'h0020);
        chk("ld_vK_M", vK_M, 16'h4000);
        chk("ld_vD_M", vD_M, 16'h1000);
        chk("ld_dt", dt, 16'h0008);

        // partial LOAD, then go silent
        s0 = ntx;
        send(8'h01);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        repeat (30) @(negedge clk);
        chk("to_early_busy", busy, 1);
        repeat (20) @(negedge clk);
        chk("to_busy", busy, 0);
        chk("to_ntx", ntx - s0, 0);
        chk("to_ic1", ic1, 16'h0040);
        chk("to_ic2", ic2, 16'h0020);

        // long RUN with a READ opcode injected mid-run
        q0 = rxq.size();
        e0 = en_cnt;
        send(8'h02);
        send(8'h00);
        send(8'h64);
        chk("run_en_start", dda_en, 1);
        repeat (10) @(negedge clk);
        send(8'h03);
        wait_idle("run100");
        chk("run100_en", en_cnt - e0, 100);
        chk("run100_len", rxq.size() - q0, 1 + CK);
        act = (q0 < rxq.size()) ? rxq[q0] : 8'hxx;
        chk("run100_ack", act, 8'hA5);

        // reset in the middle of a RUN
        send(8'h02);
        send(8'h00);
        send(8'h64);
        repeat (49) @(negedge clk);
        chk("mid_en_before", dda_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_dda_en", dda_en, 0);
        chk("mid_busy", busy, 0);
        chk("mid_tx_byte", u_if.tx_byte, 0);
        chk("mid_tx_start", u_if.tx_start, 0);
        chk("mid_ic1", ic1, 0);
        chk("mid_vK_M", vK_M, 0);
        chk("mid_dt", dt, 0);
        s0 = ntx;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        chk("post_rst_ntx", ntx - s0, 0);
        chk("post_rst_en", dda_en, 0);
        chk("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dda_sequencer.md
DDA_SEQUENCER -- requirements
Module: dda_sequencer

Interface
REQ-001 Parameter N, default 16, posit word width of every DDA operand and state variable.
REQ-002 Parameter TIMEOUT_CYC, default 50000, maximum idle clocks between argument bytes before a frame is aborted.
REQ-003 Port clk, input, 1, single clock for all logic.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port rx_valid, input, 1, one-cycle pulse marking rx_byte valid.
REQ-006 Port rx_byte, input, 8, received UART byte.
REQ-007 Port tx_busy, input, 1, UART transmitter busy.
REQ-008 Port tx_start, output, 1, one-cycle request to transmit tx_byte.
REQ-009 Port tx_byte, output, 8, byte to transmit; stable while tx_start is high.
REQ-010 Port dda_en, output, 1, DDA integrate enable; low means the DDA holds or reloads its initial conditions.
REQ-011 Ports ic1, ic2, vK_M, vD_M, dt, output, N each, DDA parameter registers.
REQ-012 Ports v1, v2, input, N each, DDA state variables.
REQ-013 Port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-014 FSM states: IDLE, ARGS, RUN, RESP, WAITTX; encoding defined in the package.
REQ-015 IDLE: an rx_valid byte is an opcode. 0x01 LOAD (expects 10 argument bytes), 0x02 RUN (expects 2), 0x03 READ (expects 0); any other value queues response 0xEE and goes to RESP.
REQ-016 ARGS: each rx_valid stores one byte, MSB first. LOAD order is ic1, ic2, vK_M, vD_M, dt. RUN loads a 16-bit step count.
REQ-017 LOAD shall write all parameter outputs together on the cycle the 10th byte arrives; a partial or aborted frame leaves them unchanged.
REQ-018 The inter-byte timer shall reset on every rx_valid in ARGS. When it reaches TIMEOUT_CYC, the FSM goes to IDLE, discards the partial frame, and transmits nothing.
REQ-019 RUN: dda_en shall go high on the cycle after the last count byte and stay high for exactly count cycles. A count of 0 never asserts dda_en. Completion queues ack 0xA5.
REQ-020 LOAD completion queues ack 0xA5.
REQ-021 READ snapshots v1 and v2 on the opcode cycle and queues 4 bytes: v1[15:8], v1[7:0], v2[15:8], v2[7:0].
REQ-022 RESP: when tx_busy is low, pulse tx_start for one cycle with the next queued byte, then enter WAITTX. WAITTX waits until tx_busy has been seen high and then low, then returns to RESP, or to IDLE when the queue is empty.
REQ-023 rx_valid in RUN, RESP or WAITTX is dropped with no other effect.
REQ-024 Operand widths are fixed at N; values are carried unmodified and no arithmetic is applied.

Reset
REQ-025 Reset values: FSM IDLE, tx_start 0, tx_byte 0x00, dda_en 0, busy 0, all parameter outputs 0, step counter and timer 0.
REQ-026 Reset asserted mid-frame, mid-RUN or mid-transmit shall take effect immediately and asynchronously. No further tx_start is issued.

Configuration
REQ-027 Macro DDA_SEQ_CHECKSUM_EN.
- Defined: every response (ack 0xA5, error 0xEE, READ data) is followed by one extra byte, the XOR of that response's bytes.
- Undefined: no checksum byte is sent and the checksum logic is absent.

Structure
REQ-028 Package dda_seq_pkg holds the opcode constants, the ACK and ERR byte constants, the FSM state enum, and the argument-count table.
REQ-029 The 8-byte response queue with its index counter is sub-module dda_seq_txq.

Verification
REQ-030 LOAD: send 01 00 40 00 20 40 00 10 00 00 08 -> ic1=0x0040, ic2=0x0020, vK_M=0x4000, vD_M=0x1000, dt=0x0008; transmits A5.
REQ-031 RUN: send 02 00 05 -> dda_en high for exactly 5 cycles, then transmits A5. Send 02 00 00 -> dda_en never rises; transmits A5.
REQ-032 READ: with v1=0x1234 and v2=0xABCD, send 03 -> transmits 12 34 AB CD; with DDA_SEQ_CHECKSUM_EN also transmits 0x40.
REQ-033 Send 7F -> transmits EE. Send 01 followed by 3 bytes, then idle for TIMEOUT_CYC -> no output, parameters unchanged, busy 0.
REQ-034 During RUN with count 100, inject 03 -> byte dropped and only A5 is transmitted. Assert rst_n low on cycle 50 of RUN -> dda_en 0 immediately and all outputs at reset values.
